// File: rtl/trng_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trng_share_arb_pkg
// Brief   : Shared types, defaults and helpers for the TRNG share arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package trng_share_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_DONE = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   localparam int C_DEF_W   = 64;
   localparam int C_DEF_TMO = 255;
   localparam int C_CNT_W   = 8;

   // Index width for v items; callers guarantee v >= 2.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trng_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; search starts just after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
   import trng_share_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] gnt,
   output logic          vld
);

   logic [PW-1:0] w_idx;

   // Walk from the farthest slot back to the nearest so the nearest set bit wins.
   always_comb begin
      gnt   = '0;
      vld   = 1'b0;
      w_idx = '0;
      for (int i = N; i >= 1; i--) begin
         w_idx = PW'((int'(ptr) + i) % N);
         if (req[w_idx]) begin
            gnt = w_idx;
            vld = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/trng_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : trng_share_arb
// Brief   : Round-robin sharing of one trng_reg among N coprocessor requesters.
// Revision: 1.0 - initial release
// ============================================================================
module trng_share_arb
   import trng_share_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int W   = C_DEF_W,
   parameter int TMO = C_DEF_TMO
) (
   input  logic                cop_clk,
   input  logic                cop_rst_n,
   input  logic [N-1:0]        req,
   output logic [N-1:0]        ack,
   output logic [N-1:0]        err,
   output logic [W-1:0]        rdn_out,
   output logic [clog2(N)-1:0] owner,
   output logic                busy,
   output logic                trn_gen,
   input  logic                trn_rdy,
   input  logic [W-1:0]        trn_rdn
);

   localparam int PW = clog2(N);

   state_e             r_state, w_state_nxt;
   logic [PW-1:0]      r_ptr, w_ptr_nxt;
   logic [PW-1:0]      r_owner, w_owner_nxt;
   logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [N-1:0]       r_ack, w_ack_nxt;
   logic [N-1:0]       r_err, w_err_nxt;
   logic [W-1:0]       r_rdn, w_rdn_nxt;
   logic               r_gen, w_gen_nxt;
   logic               r_busy, w_busy_nxt;
   logic [PW-1:0]      w_pick_idx;
   logic               w_pick_vld;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_rr_pick (
      .req (req),
      .ptr (r_ptr),
      .gnt (w_pick_idx),
      .vld (w_pick_vld)
   );

   // Outputs are computed one cycle ahead and registered, so ack/err/rdn_out
   // are high during DONE/FAIL while the decision used req in the last GEN cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = '0;
      w_err_nxt   = '0;
      w_rdn_nxt   = '0;
      w_gen_nxt   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_owner_nxt = w_pick_idx;
               w_cnt_nxt   = '0;
               w_gen_nxt   = 1'b1;
               w_state_nxt = ST_GEN;
            end
         end
         ST_GEN: begin
            w_gen_nxt = 1'b1;
            w_cnt_nxt = r_cnt + C_CNT_W'(1);
            if (trn_rdy) begin
               w_gen_nxt   = 1'b0;
               w_state_nxt = ST_DONE;
               if (req[r_owner]) begin
                  w_ack_nxt[r_owner] = 1'b1;
                  w_rdn_nxt          = trn_rdn;
               end
            end else if (r_cnt == C_CNT_W'(TMO)) begin
               w_gen_nxt          = 1'b0;
               w_err_nxt[r_owner] = 1'b1;
               w_state_nxt        = ST_FAIL;
            end
         end
         ST_DONE, ST_FAIL: begin
            w_ptr_nxt   = r_owner;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = PW'(N - 1);
            w_owner_nxt = '0;
            w_cnt_nxt   = '0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge cop_clk or negedge cop_rst_n) begin
      if (!cop_rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= PW'(N - 1);
         r_owner <= '0;
         r_cnt   <= '0;
         r_ack   <= '0;
         r_err   <= '0;
         r_rdn   <= '0;
         r_gen   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_rdn   <= w_rdn_nxt;
         r_gen   <= w_gen_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign ack     = r_ack;
   assign err     = r_err;
   assign rdn_out = r_rdn;
   assign owner   = r_owner;
   assign busy    = r_busy;
   assign trn_gen = r_gen;

endmodule
`default_nettype wire

// File: tb/tb_trng_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_trng_share_arb
// Brief   : Self-checking bench for trng_share_arb against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trng_share_arb;

   localparam int N   = 4;
   localparam int W   = 64;
   localparam int TMO = 8;

   logic         cop_clk = 1'b0;
   logic         cop_rst_n;
   logic [N-1:0] req;
   logic [N-1:0] ack;
   logic [N-1:0] err;
   logic [W-1:0] rdn_out;
   logic [1:0]   owner;
   logic         busy;
   logic         trn_gen;
   logic         trn_rdy;
   logic [W-1:0] trn_rdn;

   int n_checks = 0;
   int n_errors = 0;
   int m_ptr;

   always #5 cop_clk = ~cop_clk;

   trng_share_arb #(
      .N   (N),
      .W   (W),
      .TMO (TMO)
   ) dut (
      .cop_clk   (cop_clk),
      .cop_rst_n (cop_rst_n),
      .req       (req),
      .ack       (ack),
      .err       (err),
      .rdn_out   (rdn_out),
      .owner     (owner),
      .busy      (busy),
      .trn_gen   (trn_gen),
      .trn_rdy   (trn_rdy),
      .trn_rdn   (trn_rdn)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [N-1:0] ack_e, input logic [N-1:0] err_e,
                          input logic [W-1:0] rdn_e, input logic gen_e, input logic busy_e,
                          input int own_e);
      chk({tag, ".ack"},   64'(ack),     64'(ack_e));
      chk({tag, ".err"},   64'(err),     64'(err_e));
      chk({tag, ".rdn"},   rdn_out,      rdn_e);
      chk({tag, ".gen"},   64'(trn_gen), 64'(gen_e));
      chk({tag, ".busy"},  64'(busy),    64'(busy_e));
      chk({tag, ".owner"}, 64'(owner),   64'(own_e));
   endtask

   // Priority list is the rotation beginning one past the last owner.
   function automatic int model_pick(input logic [N-1:0] r, input int p);
      int order[$];
      for (int i = 1; i <= N; i++) order.push_back((p + i) % N);
      foreach (order[j]) if (r[order[j]]) return order[j];
      return -1;
   endfunction

   task automatic step();
      @(posedge cop_clk);
      #1;
   endtask

   // Entered in an IDLE cycle; returns in the IDLE cycle after DONE/FAIL.
   task automatic run_txn(input logic [N-1:0] add, input int d, input int drop_at,
                          input bit keep, input logic [N-1:0] late, input logic [W-1:0] word);
      int           w;
      logic [N-1:0] oh;
      bit           still;
      req = req | add;
      w   = model_pick(req, m_ptr);
      if (w < 0) return;
      oh    = '0;
      oh[w] = 1'b1;
      step();
      chk_out("grant", '0, '0, '0, 1'b1, 1'b1, w);
      for (int k = 0; k <= TMO; k++) begin
         trn_rdy = (k == d);
         trn_rdn = (k == d) ? word : {$urandom, $urandom};
         if (k == drop_at) req[w] = 1'b0;
         if (k == 0) req = req | (late & ~oh);
         still = req[w];
         step();
         if (k == d) begin
            chk_out("done", still ? oh : '0, '0, still ? word : '0, 1'b0, 1'b1, w);
            break;
         end else if (k == TMO) begin
            chk_out("fail", '0, oh, '0, 1'b0, 1'b1, w);
            break;
         end else begin
            chk_out("gen", '0, '0, '0, 1'b1, 1'b1, w);
         end
      end
      trn_rdy = 1'b0;
      if (!keep) req[w] = 1'b0;
      m_ptr = w;
      step();
      chk_out("idle", '0, '0, '0, 1'b0, 1'b0, w);
   endtask

   initial begin
      logic [N-1:0] add;
      int           d;
      int           drop;
      cop_rst_n = 1'b0;
      req       = '0;
      trn_rdy   = 1'b0;
      trn_rdn   = '0;
      m_ptr     = N - 1;
      repeat (3) @(posedge cop_clk);
      #1;
      chk_out("reset", '0, '0, '0, 1'b0, 1'b0, 0);
      cop_rst_n = 1'b1;
      step();
      chk_out("post_reset", '0, '0, '0, 1'b0, 1'b0, 0);

      run_txn(4'b0001, 2, -1, 1'b0, '0, 64'hDEADBEEF_01234567);

      for (int i = 0; i < 5; i++)
         run_txn(4'b1111, int'($urandom_range(0, 3)), -1, 1'b1, '0, {$urandom, $urandom});
      req = '0;

      run_txn(4'b0100, 3, 1, 1'b0, '0, {$urandom, $urandom});
      run_txn(4'b0101, 1, -1, 1'b0, '0, {$urandom, $urandom});
      run_txn(4'b0000, 0, -1, 1'b0, '0, {$urandom, $urandom});
      run_txn(4'b0001, 1000, -1, 1'b0, '0, {$urandom, $urandom});
      run_txn(4'b0010, TMO, -1, 1'b0, '0, {$urandom, $urandom});
      run_txn(4'b1000, 0, -1, 1'b0, '0, {$urandom, $urandom});

      for (int i = 0; i < 60; i++) begin
         add = 4'($urandom_range(0, 15));
         if ((req | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
         d    = int'($urandom_range(0, TMO + 2));
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : -1;
         run_txn(add, d, drop, ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom});
      end

      req = 4'b0110;
      step();
      chk_out("rst_gen0", '0, '0, '0, 1'b1, 1'b1, model_pick(4'b0110, m_ptr));
      step();
      #2;
      cop_rst_n = 1'b0;
      #1;
      chk_out("async_rst", '0, '0, '0, 1'b0, 1'b0, 0);
      @(posedge cop_clk);
      #1;
      req       = '0;
      cop_rst_n = 1'b1;
      m_ptr     = N - 1;
      step();
      chk_out("rst_idle", '0, '0, '0, 1'b0, 1'b0, 0);
      run_txn(4'b1111, 1, -1, 1'b0, '0, {$urandom, $urandom});
      req = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
